// File: rtl/movimiento_monitor.sv
// Rebuilds the wheelchair movement code from the H-bridge driver pins, with glitch
// filtering, illegal-pattern fault latching and a saturating dwell counter.
module movimiento_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int DWELL_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         right_in,
    input  logic [1:0]         left_in,
    input  logic               clear_fault,
    output logic [2:0]         estado,
    output logic               estado_valid,
    output logic               change_pulse,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [DWELL_W-1:0] dwell
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = {DWELL_W{1'b1}};

    typedef enum logic [1:0] {UNKNOWN, TRACK, FAULT} state_t;

    logic [3:0]       sync_a, sync_b, cand;
    logic             primed, cand_vld;
    logic [CNT_W-1:0] cnt;
    logic             stable;

    // The filter ignores the synchronizer for one cycle after reset so the flushed
    // reset value and a fresh pin change see the same acceptance latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a   <= '0;
            sync_b   <= '0;
            primed   <= 1'b0;
            cand     <= '0;
            cand_vld <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_a <= {right_in, left_in};
            sync_b <= sync_a;
            primed <= 1'b1;
            if (!primed) begin
                cand_vld <= 1'b0;
                cnt      <= '0;
            end else if (!cand_vld || sync_b != cand) begin
                cand     <= sync_b;
                cand_vld <= 1'b1;
                cnt      <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign stable = cand_vld && (cnt == CNT_MAX);

    logic       legal;
    logic [2:0] code;
    logic [1:0] cause;

    always_comb begin
        legal = 1'b0;
        code  = 3'b000;
        cause = 2'b00;
        if (cand[3:2] == 2'b11 || cand[1:0] == 2'b11) begin
            cause = 2'b01;
        end else begin
            case (cand)
                4'b0000: begin legal = 1'b1; code = 3'b000; end
                4'b0101: begin legal = 1'b1; code = 3'b001; end
                4'b1010: begin legal = 1'b1; code = 3'b010; end
                4'b0110: begin legal = 1'b1; code = 3'b011; end
                4'b1001: begin legal = 1'b1; code = 3'b100; end
                default: cause = 2'b10;
            endcase
        end
    end

    state_t             state, state_n;
    logic [2:0]         estado_n;
    logic               pulse_n;
    logic [1:0]         fault_code_n;
    logic [DWELL_W-1:0] dwell_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= UNKNOWN;
            estado       <= 3'b000;
            change_pulse <= 1'b0;
            fault_code   <= 2'b00;
            dwell        <= '0;
        end else begin
            state        <= state_n;
            estado       <= estado_n;
            change_pulse <= pulse_n;
            fault_code   <= fault_code_n;
            dwell        <= dwell_n;
        end
    end

    always_comb begin
        state_n      = state;
        estado_n     = estado;
        pulse_n      = 1'b0;
        fault_code_n = fault_code;
        dwell_n      = dwell;
        case (state)
            UNKNOWN: begin
                dwell_n = '0;
                if (stable && legal) begin
                    state_n  = TRACK;
                    estado_n = code;
                    pulse_n  = 1'b1;
                end else if (stable) begin
                    state_n      = FAULT;
                    estado_n     = 3'b111;
                    fault_code_n = cause;
                end
            end
            TRACK: begin
                if (stable && !legal) begin
                    state_n      = FAULT;
                    estado_n     = 3'b111;
                    fault_code_n = cause;
                    dwell_n      = '0;
                end else if (stable && code != estado) begin
                    estado_n = code;
                    pulse_n  = 1'b1;
                    dwell_n  = '0;
                end else if (dwell != DWELL_MAX) begin
                    dwell_n = dwell + DWELL_W'(1);
                end
            end
            FAULT: begin
                dwell_n = '0;
                // First cause stays latched; only a clear on a settled legal pattern exits.
                if (clear_fault && stable && legal) begin
                    state_n      = TRACK;
                    estado_n     = code;
                    pulse_n      = 1'b1;
                    fault_code_n = 2'b00;
                end
            end
            default: state_n = UNKNOWN;
        endcase
    end

    assign estado_valid = (state == TRACK);
    assign fault        = (state == FAULT);

endmodule

// File: tb/tb_movimiento_monitor.sv
// Scoreboard bench: a sample-window reference model predicts every cycle's outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_movimiento_monitor;

    localparam int S  = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    right_in = 2'b00, left_in = 2'b00;
    logic          clear_fault = 1'b0;
    logic [2:0]    estado;
    logic          estado_valid, change_pulse, fault;
    logic [1:0]    fault_code;
    logic [DW-1:0] dwell;

    movimiento_monitor #(.STABLE_CYCLES(S), .DWELL_W(DW)) dut (
        .clk(clk), .rst(rst), .right_in(right_in), .left_in(left_in),
        .clear_fault(clear_fault), .estado(estado), .estado_valid(estado_valid),
        .change_pulse(change_pulse), .fault(fault), .fault_code(fault_code), .dwell(dwell)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    est;
        logic          vld;
        logic          pulse;
        logic          flt;
        logic [1:0]    fc;
        logic [DW-1:0] dw;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: pins sampled on each edge go into a history; a pattern is
    // settled when the S samples ending two edges back all agree. Index 0 is the
    // reset image of the synchronizer, anything earlier does not exist.
    int         hist[$];
    int         mode;         // 0 unknown, 1 tracking, 2 faulted
    logic [2:0] m_est;
    logic [1:0] m_fc;
    int         m_dw;
    bit         m_pulse, m_stable, m_legal;
    int         m_pat;
    logic [2:0] m_code;
    logic [1:0] m_cause;

    function automatic void classify(input int p, output bit legal,
                                     output logic [2:0] code, output logic [1:0] cause);
        int r, l;
        r = p / 4;
        l = p % 4;
        legal = 1'b0; code = 3'd0; cause = 2'd0;
        if (r == 3 || l == 3)      cause = 2'd1;
        else if (r == l)           begin legal = 1'b1; code = 3'(r); end
        else if (r == 1 && l == 2) begin legal = 1'b1; code = 3'd3; end
        else if (r == 2 && l == 1) begin legal = 1'b1; code = 3'd4; end
        else                       cause = 2'd2;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            hist.delete();
            hist.push_back(0);
            mode = 0; m_est = 3'd0; m_fc = 2'd0; m_dw = 0;
        end else begin
            m_stable = 1'b0;
            m_pat    = 0;
            if (hist.size() >= S + 2) begin
                m_pat    = hist[hist.size()-3];
                m_stable = 1'b1;
                for (int i = hist.size() - S - 2; i <= hist.size() - 3; i++)
                    if (hist[i] != m_pat) m_stable = 1'b0;
            end
            classify(m_pat, m_legal, m_code, m_cause);
            m_pulse = 1'b0;
            if (mode == 0) begin
                if (m_stable && m_legal) begin mode = 1; m_est = m_code; m_pulse = 1'b1; m_dw = 0; end
                else if (m_stable) begin mode = 2; m_est = 3'd7; m_fc = m_cause; end
            end else if (mode == 1) begin
                if (m_stable && !m_legal) begin mode = 2; m_est = 3'd7; m_fc = m_cause; m_dw = 0; end
                else if (m_stable && m_code != m_est) begin m_est = m_code; m_pulse = 1'b1; m_dw = 0; end
                else if (m_dw < (1 << DW) - 1) m_dw = m_dw + 1;
            end else begin
                m_dw = 0;
                if (clear_fault && m_stable && m_legal) begin
                    mode = 1; m_est = m_code; m_pulse = 1'b1; m_fc = 2'd0;
                end
            end
            exp_q.push_back('{m_est, mode == 1, m_pulse, mode == 2, m_fc, DW'(m_dw)});
            hist.push_back(int'({right_in, left_in}));
            if (hist.size() > 16) void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        obs_t e, a;
        if (!rst) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
            end else begin
                e = exp_q.pop_front();
                a = '{estado, estado_valid, change_pulse, fault, fault_code, dwell};
                if (a !== e)
                    begin
                        bad++;
                        $display("FAIL cycle_check at %0t: got est=%0d vld=%0b pulse=%0b flt=%0b fc=%0d dw=%0d want est=%0d vld=%0b pulse=%0b flt=%0b fc=%0d dw=%0d",
                                 $time, a.est, a.vld, a.pulse, a.flt, a.fc, a.dw,
                                 e.est, e.vld, e.pulse, e.flt, e.fc, e.dw);
                    end
            end
        end
    end

    task automatic drive(input logic [3:0] p, input int n, input bit clr);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            {right_in, left_in} = p;
            clear_fault = clr && (i == 0);
        end
    endtask

    task automatic reset_pulse(input int hold);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({estado, estado_valid, change_pulse, fault, fault_code, dwell} !== '0) begin
            bad++;
            $display("FAIL reset_values: got est=%0d vld=%0b pulse=%0b flt=%0b fc=%0d dw=%0d want all zero",
                     estado, estado_valid, change_pulse, fault, fault_code, dwell);
        end
        repeat (hold) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    logic [3:0] legal_pats [5] = '{4'b0000, 4'b0101, 4'b1010, 4'b0110, 4'b1001};
    logic [3:0] bad_pats   [5] = '{4'b1100, 4'b0011, 4'b0100, 4'b0001, 4'b1111};

    initial begin
        reset_pulse(2);
        drive(4'b0000, 10, 1'b0);                 // stop accepted after reset
        drive(4'b0101, 12, 1'b0);                 // forward
        drive(4'b0110, 3, 1'b0);                  // short glitch, filtered
        drive(4'b0101, 10, 1'b0);
        drive(4'b1100, 10, 1'b0);                 // shoot-through
        drive(4'b0100, 10, 1'b0);                 // mismatch, cause stays
        drive(4'b0100, 4, 1'b1);                  // clear while illegal
        drive(4'b0000, 8, 1'b0);
        drive(4'b0000, 4, 1'b1);                  // clear on settled stop
        drive(4'b0101, (1 << DW) + 14, 1'b0);     // dwell saturation
        reset_pulse(2);
        drive(4'b0101, 12, 1'b0);
        for (int k = 0; k < 70; k++) begin
            int idx;
            idx = $urandom_range(0, 19);
            drive(idx < 16 ? legal_pats[idx % 5] : bad_pats[idx % 5],
                  $urandom_range(1, 9), $urandom_range(0, 3) == 0);
        end
        drive(4'b0000, 8, 1'b1);
        drive(4'b0000, 10, 1'b0);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
